maxnet_update: RTL and testbench

Iterative MaxNet lateral-inhibition engine that sits directly upstream of the output checker. It loads four activations with their labels and repeatedly applies x_k ← ReLU(x_k − ε·Σ_{j≠k} x_j) in Q16.16 fixed point using one shared multiplier. After each iteration it presents the activation/label set to the checker and samples the checker's convergence flag. It stops on convergence or when an iteration budget runs out.

---
 rtl/maxnet_update.sv | 181 ++++++++++++++++++
 tb/tb_maxnet_update.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_update.sv
// rtl/maxnet_update.sv - four-neuron MaxNet lateral-inhibition engine, one shared multiplier
module maxnet_update #(
    parameter logic [15:0] EPS      = 16'h2000,
    parameter int          FRAC     = 16,
    parameter int          MAX_ITER = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x_in1,
    input  logic [31:0] x_in2,
    input  logic [31:0] x_in3,
    input  logic [31:0] x_in4,
    input  logic [31:0] a_in1,
    input  logic [31:0] a_in2,
    input  logic [31:0] a_in3,
    input  logic [31:0] a_in4,
    input  logic        converged,
    output logic [31:0] x1,
    output logic [31:0] x2,
    output logic [31:0] x3,
    output logic [31:0] x4,
    output logic [31:0] a1,
    output logic [31:0] a2,
    output logic [31:0] a3,
    output logic [31:0] a4,
    output logic        iter_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  iter_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SUM     = 3'd2,
        S_UPD     = 3'd3,
        S_PRESENT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0] MAX_ITER_W = 8'(MAX_ITER);

    state_t              state, state_nxt;
    logic [1:0]          k;
    logic [31:0]         x_r [4];
    logic [31:0]         a_r [4];
    logic signed [33:0]  s_r;
    logic [7:0]          iter_r;
    logic                timeout_r;

    logic [31:0]         x_in_arr [4];
    logic [31:0]         a_in_arr [4];
    logic [31:0]         x_cur;
    logic signed [33:0]  x_cur_ext;
    logic signed [33:0]  sum_all;
    logic signed [33:0]  others;
    logic signed [49:0]  prod;
    logic signed [49:0]  p_full;
    logic signed [49:0]  n_full;
    logic [31:0]         x_new;
    logic                load_req;

    assign x_in_arr[0] = x_in1;
    assign x_in_arr[1] = x_in2;
    assign x_in_arr[2] = x_in3;
    assign x_in_arr[3] = x_in4;
    assign a_in_arr[0] = a_in1;
    assign a_in_arr[1] = a_in2;
    assign a_in_arr[2] = a_in3;
    assign a_in_arr[3] = a_in4;

    assign load_req = start && ((state == S_IDLE) || (state == S_DONE));

    // Jacobi update: S stays frozen across the four UPD cycles, so each neuron
    // sees the pre-iteration total even though earlier neurons were rewritten.
    always_comb begin
        sum_all   = $signed({{2{x_r[0][31]}}, x_r[0]}) + $signed({{2{x_r[1][31]}}, x_r[1]})
                  + $signed({{2{x_r[2][31]}}, x_r[2]}) + $signed({{2{x_r[3][31]}}, x_r[3]});
        x_cur     = x_r[k];
        x_cur_ext = $signed({{2{x_cur[31]}}, x_cur});
        others    = s_r - x_cur_ext;
        prod      = $signed({34'd0, EPS}) * $signed({{16{others[33]}}, others});
        p_full    = prod >>> FRAC;
        n_full    = $signed({{16{x_cur_ext[33]}}, x_cur_ext}) - p_full;
        x_new     = (n_full[49] || (n_full == '0)) ? 32'd0 : n_full[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_SUM;
            S_SUM:     state_nxt = S_UPD;
            S_UPD:     if (k == 2'd3) state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (converged || (iter_r == MAX_ITER_W)) state_nxt = S_DONE;
                else                                     state_nxt = S_SUM;
            end
            S_DONE:    if (start) state_nxt = S_LOAD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        iter_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_LOAD, S_SUM, S_UPD: busy = 1'b1;
            S_PRESENT: begin
                busy       = 1'b1;
                iter_valid = 1'b1;
            end
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                x_r[i] <= '0;
                a_r[i] <= '0;
            end
            s_r       <= '0;
            k         <= '0;
            iter_r    <= '0;
            timeout_r <= 1'b0;
        end else begin
            // Clearing on the start edge lets the LOAD cycle already show a fresh count.
            if (load_req) begin
                iter_r    <= '0;
                timeout_r <= 1'b0;
            end
            case (state)
                S_LOAD: begin
                    for (int i = 0; i < 4; i++) begin
                        x_r[i] <= x_in_arr[i][31] ? 32'd0 : x_in_arr[i];
                        a_r[i] <= a_in_arr[i];
                    end
                    k <= '0;
                end
                S_SUM: begin
                    s_r <= sum_all;
                    k   <= '0;
                end
                S_UPD: begin
                    x_r[k] <= x_new;
                    k      <= k + 2'd1;
                    if (k == 2'd3) iter_r <= iter_r + 8'd1;
                end
                S_PRESENT: begin
                    if (!converged && (iter_r == MAX_ITER_W)) timeout_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign x1         = x_r[0];
    assign x2         = x_r[1];
    assign x3         = x_r[2];
    assign x4         = x_r[3];
    assign a1         = a_r[0];
    assign a2         = a_r[1];
    assign a3         = a_r[2];
    assign a4         = a_r[3];
    assign timeout    = timeout_r;
    assign iter_count = iter_r;

endmodule

// File: tb/tb_maxnet_update.sv
// tb/tb_maxnet_update.sv - directed vector bench for maxnet_update
module tb_maxnet_update;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        start2;
    logic [31:0] x_in [4];
    logic [31:0] a_in [4];
    logic        conv;
    logic        conv_mode;
    logic        conv2;

    logic [31:0] xo [4];
    logic [31:0] ao [4];
    logic        iv, busy, done, tmo;
    logic [7:0]  ic;

    logic [31:0] yo [4];
    logic [31:0] bo [4];
    logic        iv2, busy2, done2, tmo2;
    logic [7:0]  ic2;

    maxnet_update #(.EPS(16'h2000), .FRAC(16), .MAX_ITER(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in1(x_in[0]), .x_in2(x_in[1]), .x_in3(x_in[2]), .x_in4(x_in[3]),
        .a_in1(a_in[0]), .a_in2(a_in[1]), .a_in3(a_in[2]), .a_in4(a_in[3]),
        .converged(conv),
        .x1(xo[0]), .x2(xo[1]), .x3(xo[2]), .x4(xo[3]),
        .a1(ao[0]), .a2(ao[1]), .a3(ao[2]), .a4(ao[3]),
        .iter_valid(iv), .busy(busy), .done(done), .timeout(tmo), .iter_count(ic)
    );

    maxnet_update #(.EPS(16'h2000), .FRAC(16), .MAX_ITER(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .x_in1(x_in[0]), .x_in2(x_in[1]), .x_in3(x_in[2]), .x_in4(x_in[3]),
        .a_in1(a_in[0]), .a_in2(a_in[1]), .a_in3(a_in[2]), .a_in4(a_in[3]),
        .converged(conv2),
        .x1(yo[0]), .x2(yo[1]), .x3(yo[2]), .x4(yo[3]),
        .a1(bo[0]), .a2(bo[1]), .a3(bo[2]), .a4(bo[3]),
        .iter_valid(iv2), .busy(busy2), .done(done2), .timeout(tmo2), .iter_count(ic2)
    );

    // Checker model: valid once at most one activation is still nonzero.
    logic [2:0] nz;
    always_comb begin
        nz   = 3'(xo[0] != 0) + 3'(xo[1] != 0) + 3'(xo[2] != 0) + 3'(xo[3] != 0);
        conv = conv_mode && (nz <= 3'd1);
    end

    typedef struct packed {
        logic [3:0][31:0] xi;
        logic [3:0][31:0] e1;
        logic [3:0][31:0] e2;
    } vec_t;

    vec_t vt [6];
    int   checks = 0;
    int   errors = 0;
    int   n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_iv(output int cnt);
        cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (iv) begin
                cnt = i;
                return;
            end
        end
    endtask

    task automatic wait_done(input bit second, output int cnt);
        cnt = 0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if ((second && done2) || (!second && done)) begin
                cnt = i;
                return;
            end
        end
    endtask

    task automatic set_x(input logic [3:0][31:0] v);
        for (int i = 0; i < 4; i++) begin
            x_in[i] = v[i];
            a_in[i] = 32'hA000_0000 + 32'(i) + {v[0][19:16], 8'h0};
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; conv_mode = 1'b0; conv2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_in[i] = '0;
            a_in[i] = '0;
        end

        vt[0].xi = {32'h10000, 32'h20000, 32'h30000, 32'h40000};
        vt[0].e1 = {32'h0, 32'h10000, 32'h22000, 32'h34000};
        vt[0].e2 = {32'h0, 32'h05400, 32'h19800, 32'h2DC00};
        vt[1].xi = {32'h10000, 32'h10000, 32'h10000, 32'h10000};
        vt[1].e1 = {32'h0A000, 32'h0A000, 32'h0A000, 32'h0A000};
        vt[1].e2 = {32'h06400, 32'h06400, 32'h06400, 32'h06400};
        vt[2].xi = {32'h0, 32'h0, 32'h20000, 32'hFFFF0000};
        vt[2].e1 = {32'h0, 32'h0, 32'h20000, 32'h0};
        vt[2].e2 = {32'h0, 32'h0, 32'h20000, 32'h0};
        vt[3].xi = {32'h0, 32'h0, 32'h0, 32'h80000};
        vt[3].e1 = {32'h0, 32'h0, 32'h0, 32'h80000};
        vt[3].e2 = {32'h0, 32'h0, 32'h0, 32'h80000};
        vt[4].xi = {32'h0, 32'h0, 32'h10000, 32'h10000};
        vt[4].e1 = {32'h0, 32'h0, 32'h0E000, 32'h0E000};
        vt[4].e2 = {32'h0, 32'h0, 32'h0C400, 32'h0C400};
        vt[5].xi = {32'h0, 32'h0, 32'h00001, 32'h10001};
        vt[5].e1 = {32'h0, 32'h0, 32'h0, 32'h10001};
        vt[5].e2 = {32'h0, 32'h0, 32'h0, 32'h10001};

        #3;
        chk("reset_x1", xo[0], 32'h0);
        chk("reset_a1", ao[0], 32'h0);
        chk("reset_flags", {28'h0, iv, busy, done, tmo}, 32'h0);
        chk("reset_iter_count", {24'h0, ic}, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            do_reset();
            conv_mode = 1'b0;
            set_x(vt[v].xi);
            do_start();
            chk($sformatf("v%0d_busy_load", v), {31'h0, busy}, 32'h1);
            wait_iv(n);
            chk($sformatf("v%0d_lat1", v), n, 6);
            chk($sformatf("v%0d_ic1", v), {24'h0, ic}, 32'h1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d_it1_x%0d", v, i + 1), xo[i], vt[v].e1[i]);
                chk($sformatf("v%0d_a%0d", v, i + 1), ao[i], a_in[i]);
            end
            wait_iv(n);
            chk($sformatf("v%0d_lat2", v), n, 6);
            for (int i = 0; i < 4; i++)
                chk($sformatf("v%0d_it2_x%0d", v, i + 1), xo[i], vt[v].e2[i]);
        end

        do_reset();
        set_x(vt[1].xi);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_done(1'b1, n);
        chk("budget_cycles", n, 13);
        chk("budget_timeout", {31'h0, tmo2}, 32'h1);
        chk("budget_ic", {24'h0, ic2}, 32'h2);
        chk("budget_busy", {31'h0, busy2}, 32'h0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("budget_x%0d", i + 1), yo[i], 32'h06400);

        do_reset();
        conv_mode = 1'b1;
        set_x(vt[0].xi);
        do_start();
        wait_done(1'b0, n);
        chk("conv_done", {31'h0, done}, 32'h1);
        chk("conv_timeout", {31'h0, tmo}, 32'h0);
        chk("conv_x2", xo[1], 32'h0);
        chk("conv_x3", xo[2], 32'h0);
        chk("conv_x4", xo[3], 32'h0);
        chk("conv_x1_nonzero", {31'h0, xo[0] != 0}, 32'h1);
        chk("conv_winner_label", ao[0], a_in[0]);
        chk("conv_total_cycles", n, 1 + 6 * int'(ic));

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done", {31'h0, done}, 32'h0);
        chk("restart_ic", {24'h0, ic}, 32'h0);
        chk("restart_busy", {31'h0, busy}, 32'h1);

        do_reset();
        conv_mode = 1'b1;
        set_x({32'h0, 32'h0, 32'h0, 32'hFFFF0000});
        do_start();
        chk("clamp_x1", xo[0], 32'h0);
        wait_done(1'b0, n);
        chk("clamp_cycles", n, 7);
        chk("clamp_ic", {24'h0, ic}, 32'h1);
        chk("clamp_timeout", {31'h0, tmo}, 32'h0);

        do_reset();
        conv_mode = 1'b0;
        set_x(vt[0].xi);
        do_start();
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_iv(n);
        chk("ignore_start_lat", n, 2);
        chk("ignore_start_x1", xo[0], 32'h34000);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_x1", xo[0], 32'h0);
        chk("async_a1", ao[0], 32'h0);
        chk("async_flags", {28'h0, iv, busy, done, tmo}, 32'h0);
        chk("async_ic", {24'h0, ic}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        wait_iv(n);
        chk("reload_lat", n, 6);
        chk("reload_x1", xo[0], 32'h34000);
        chk("reload_x2", xo[1], 32'h22000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
